// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini SRC control unit: opcodes, sequencer states,
// instruction classes and the bundled control-word layout.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_ALUI, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IO, C_MFHILO, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, r15in;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, irin;
    logic yin, zin, zhiout, zloout, hiin, hiout, loin, loout, cout;
    logic inportout, outportin, conin, read, write;
  } ctrl_t;

  function automatic logic [2:0] t_index(input state_t s);
    logic [2:0] idx;
    idx = 3'd0;
    case (s)
      S_T1:    idx = 3'd1;
      S_T2:    idx = 3'd2;
      S_T3:    idx = 3'd3;
      S_T4:    idx = 3'd4;
      S_T5:    idx = 3'd5;
      S_T6:    idx = 3'd6;
      S_T7:    idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Combinational opcode decode: instruction class and the T-index of the
// final execute step for that class.
module instr_decoder
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_t    iclass_o,
  output logic [2:0] last_step_o
);

  always_comb begin
    iclass_o    = C_NOP;
    last_step_o = 3'd3;
    unique case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        iclass_o    = C_ALU3;
        last_step_o = 3'd5;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        iclass_o    = C_ALUI;
        last_step_o = 3'd5;
      end
      OP_MUL, OP_DIV: begin
        iclass_o    = C_MULDIV;
        last_step_o = 3'd6;
      end
      OP_NEG, OP_NOT: begin
        iclass_o    = C_UNARY;
        last_step_o = 3'd4;
      end
      OP_LD: begin
        iclass_o    = C_LD;
        last_step_o = 3'd7;
      end
      OP_LDI: begin
        iclass_o    = C_LDI;
        last_step_o = 3'd5;
      end
      OP_ST: begin
        iclass_o    = C_ST;
        last_step_o = 3'd7;
      end
      OP_BR: begin
        iclass_o    = C_BR;
        last_step_o = 3'd6;
      end
      OP_JR:            iclass_o = C_JR;
      OP_JAL: begin
        iclass_o    = C_JAL;
        last_step_o = 3'd4;
      end
      OP_IN, OP_OUT:    iclass_o = C_IO;
      OP_MFHI, OP_MFLO: iclass_o = C_MFHILO;
      OP_HALT:          iclass_o = C_HALT;
      default:          iclass_o = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step sequencer for Mini SRC: fetch T0-T2, execute T3-T7,
// with RESET and HALT states and Moore control decode.
module control_unit
  import mini_src_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        con_ff,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15in,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        OutPortin,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        clr
);

  state_t     state_q, state_d;
  iclass_t    iclass;
  logic [2:0] last_step;
  logic [2:0] step;
  logic [4:0] opcode;
  logic       at_last;
  state_t     end_state;
  ctrl_t      ctl;
  logic [4:0] alu_op_c;

  // Register fields are routed to the datapath directly; only the opcode is decoded here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  assign opcode = IR[31:27];
  assign step   = t_index(state_q);

  instr_decoder u_dec (
    .opcode_i    (opcode),
    .iclass_o    (iclass),
    .last_step_o (last_step)
  );

  assign at_last   = (step == last_step);
  assign end_state = (iclass == C_HALT || stop) ? S_HALT : S_T0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = at_last ? end_state : S_T4;
      S_T4:    state_d = at_last ? end_state : S_T5;
      S_T5:    state_d = at_last ? end_state : S_T6;
      S_T6:    state_d = at_last ? end_state : S_T7;
      S_T7:    state_d = end_state;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    ctl      = '0;
    alu_op_c = '0;
    unique case (state_q)
      S_T0: begin
        ctl.pcout = 1'b1; ctl.marin = 1'b1; ctl.incpc = 1'b1; ctl.zin = 1'b1;
      end
      S_T1: begin
        ctl.zloout = 1'b1; ctl.pcin = 1'b1; ctl.read = 1'b1; ctl.mdrin = 1'b1;
      end
      S_T2: begin
        ctl.mdrout = 1'b1; ctl.irin = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        unique case (iclass)
          C_ALU3, C_ALUI: begin
            case (step)
              3'd3: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
              3'd4: begin
                if (iclass == C_ALU3) begin
                  ctl.grc  = 1'b1;
                  ctl.rout = 1'b1;
                end else begin
                  ctl.cout = 1'b1;
                end
                ctl.zin  = 1'b1;
                alu_op_c = opcode;
              end
              3'd5: begin ctl.zloout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (step)
              3'd3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
              3'd4: begin
                ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1;
                alu_op_c = opcode;
              end
              3'd5: begin ctl.zloout = 1'b1; ctl.loin = 1'b1; end
              3'd6: begin ctl.zhiout = 1'b1; ctl.hiin = 1'b1; end
              default: ;
            endcase
          end
          C_UNARY: begin
            case (step)
              3'd3: begin
                ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zin = 1'b1;
                alu_op_c = opcode;
              end
              3'd4: begin ctl.zloout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
              default: ;
            endcase
          end
          // ld, ldi and st share the base+offset address computation in T3-T4.
          C_LD, C_LDI, C_ST: begin
            case (step)
              3'd3: begin ctl.grb = 1'b1; ctl.baout = 1'b1; ctl.yin = 1'b1; end
              3'd4: begin
                ctl.cout = 1'b1; ctl.zin = 1'b1;
                alu_op_c = OP_ADD;
              end
              3'd5: begin
                ctl.zloout = 1'b1;
                if (iclass == C_LDI) begin
                  ctl.gra = 1'b1;
                  ctl.rin = 1'b1;
                end else begin
                  ctl.marin = 1'b1;
                end
              end
              3'd6: begin
                if (iclass == C_ST) begin
                  ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdrin = 1'b1;
                end else begin
                  ctl.read = 1'b1; ctl.mdrin = 1'b1;
                end
              end
              3'd7: begin
                if (iclass == C_ST) begin
                  ctl.write = 1'b1;
                end else begin
                  ctl.mdrout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
                end
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (step)
              3'd3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.conin = 1'b1; end
              3'd4: begin ctl.pcout = 1'b1; ctl.yin = 1'b1; end
              3'd5: begin
                ctl.cout = 1'b1; ctl.zin = 1'b1;
                alu_op_c = OP_ADD;
              end
              3'd6: begin ctl.zloout = 1'b1; ctl.pcin = con_ff; end
              default: ;
            endcase
          end
          C_JR: begin
            if (step == 3'd3) begin
              ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1;
            end
          end
          C_JAL: begin
            case (step)
              3'd3: begin ctl.pcout = 1'b1; ctl.r15in = 1'b1; end
              3'd4: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1; end
              default: ;
            endcase
          end
          // in/out and mfhi/mflo differ only in opcode bit 0.
          C_IO: begin
            if (step == 3'd3) begin
              ctl.gra = 1'b1;
              if (opcode[0]) begin
                ctl.rout = 1'b1; ctl.outportin = 1'b1;
              end else begin
                ctl.inportout = 1'b1; ctl.rin = 1'b1;
              end
            end
          end
          C_MFHILO: begin
            if (step == 3'd3) begin
              ctl.gra = 1'b1; ctl.rin = 1'b1;
              if (opcode[0]) ctl.loout = 1'b1;
              else           ctl.hiout = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.rin;
  assign Rout      = ctl.rout;
  assign BAout     = ctl.baout;
  assign R15in     = ctl.r15in;
  assign PCout     = ctl.pcout;
  assign PCin      = ctl.pcin;
  assign IncPC     = ctl.incpc;
  assign MARin     = ctl.marin;
  assign MDRin     = ctl.mdrin;
  assign MDRout    = ctl.mdrout;
  assign IRin      = ctl.irin;
  assign Yin       = ctl.yin;
  assign Zin       = ctl.zin;
  assign ZHIout    = ctl.zhiout;
  assign ZLOout    = ctl.zloout;
  assign HIin      = ctl.hiin;
  assign HIout     = ctl.hiout;
  assign LOin      = ctl.loin;
  assign LOout     = ctl.loout;
  assign Cout      = ctl.cout;
  assign InPortout = ctl.inportout;
  assign OutPortin = ctl.outportin;
  assign CONin     = ctl.conin;
  assign Read      = ctl.read;
  assign Write     = ctl.write;
  assign alu_op    = alu_op_c;
  assign run       = (state_q != S_RESET) && (state_q != S_HALT);
  assign clr       = (state_q == S_RESET);

endmodule
